host_mem_arbiter: RTL

Shares the single host memory OBI port between NUM_REQ requesters, such as the e_gpu fetch/LSU path, a DMA and a host-side loader. Requests are forwarded combinationally and arbitrated round-robin. The arbiter holds its choice while the memory stalls, tracks up to MAX_OUTSTANDING in-flight transactions in an ID FIFO, and routes each rvalid/rdata back to the requester that issued it. It sits between the requesters' OBI manager ports and host_mem's host_mem_req/host_mem_rsp.

---
 rtl/host_mem_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/host_mem_arbiter.sv
// Round-robin arbiter that shares one OBI host memory port between NUM_REQ requesters.
// Define HOST_ARB_FIXED_PRIO_EN to build a fixed-priority arbiter instead (lowest index wins).
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | arbitrate among req_i each cycle while the ID FIFO has room
// ST_HOLD | memory stalled the last winner; keep presenting sel_q until gnt
module host_mem_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_REQ-1:0]           req_i,
    input  logic [NUM_REQ-1:0]           we_i,
    input  logic [NUM_REQ*DATA_W/8-1:0]  be_i,
    input  logic [NUM_REQ*ADDR_W-1:0]    addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]    wdata_i,
    output logic [NUM_REQ-1:0]           gnt_o,
    output logic [NUM_REQ-1:0]           rvalid_o,
    output logic [DATA_W-1:0]            rdata_o,
    output logic                         mem_req_o,
    output logic                         mem_we_o,
    output logic [DATA_W/8-1:0]          mem_be_o,
    output logic [ADDR_W-1:0]            mem_addr_o,
    output logic [DATA_W-1:0]            mem_wdata_o,
    input  logic                         mem_gnt_i,
    input  logic                         mem_rvalid_i,
    input  logic [DATA_W-1:0]            mem_rdata_i,
    output logic                         err_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int SEL_W = $clog2(NUM_REQ);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   fifo_q [MAX_OUTSTANDING];
    logic [SEL_W-1:0]   fifo_d [MAX_OUTSTANDING];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifndef HOST_ARB_FIXED_PRIO_EN
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
`endif

    logic [SEL_W-1:0]   winner;
    logic [SEL_W-1:0]   mux_sel;
    logic [SEL_W-1:0]   head;
    logic               can_issue;
    logic               issue;
    logic               grant;
    logic               pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef HOST_ARB_FIXED_PRIO_EN
    always_comb begin : fixed_arb
        logic [SEL_W-1:0] cand;
        winner = '0;
        cand   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = SEL_W'(i);
            if (req_i[cand]) begin
                winner = cand;
            end
        end
    end
`else
    // First requester at or after rr_ptr_q, wrapping modulo NUM_REQ.
    always_comb begin : rr_arb
        int               idx;
        logic             found;
        logic [SEL_W-1:0] cand;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = SEL_W'(idx);
            if (!found && req_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end
`endif

    // Issue is gated on the registered count only, so a same-cycle pop never
    // creates a combinational path from mem_rvalid_i to mem_req_o.
    always_comb begin
        can_issue = (cnt_q < CNT_W'(MAX_OUTSTANDING));
        mux_sel   = winner;
        issue     = 1'b0;
        if (state_q == ST_HOLD) begin
            mux_sel = sel_q;
            issue   = 1'b1;
        end else begin
            issue = can_issue && (|req_i);
        end
        if (rst_i) begin
            issue = 1'b0;
        end
        grant = issue && mem_gnt_i;
        head  = fifo_q[rd_ptr_q];
        pop   = mem_rvalid_i && (cnt_q != '0) && !rst_i;
    end

    always_comb begin
        mem_req_o   = issue;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (!rst_i) begin
            mem_we_o    = we_i[mux_sel];
            mem_be_o    = be_i[int'(mux_sel)*BE_W +: BE_W];
            mem_addr_o  = addr_i[int'(mux_sel)*ADDR_W +: ADDR_W];
            mem_wdata_o = wdata_i[int'(mux_sel)*DATA_W +: DATA_W];
        end
        gnt_o    = grant ? (ONE_HOT0 << mux_sel) : '0;
        rvalid_o = pop ? (ONE_HOT0 << head) : '0;
        err_o    = mem_rvalid_i && (cnt_q == '0) && !rst_i;
    end

    assign rdata_o = mem_rdata_i;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        fifo_d   = fifo_q;
`ifndef HOST_ARB_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (issue && !mem_gnt_i) begin
                    state_d = ST_HOLD;
                    sel_d   = winner;
                end
            end
            ST_HOLD: begin
                if (grant) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (grant) begin
            fifo_d[wr_ptr_q] = mux_sel;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
`ifndef HOST_ARB_FIXED_PRIO_EN
            rr_ptr_d = (mux_sel == SEL_W'(NUM_REQ - 1)) ? '0 : mux_sel + 1'b1;
`endif
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({grant, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            fifo_q   <= '{default: '0};
`ifndef HOST_ARB_FIXED_PRIO_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            fifo_q   <= fifo_d;
`ifndef HOST_ARB_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

endmodule
